// File: rtl/frac_cen_gen.sv
// Fractional clock-enable generator: one-cycle pulses at average rate f_clk*n/m,
// plus binary sub-multiples of that rate and a mid-period (180 degree) pulse.
module frac_cen_gen #(
  parameter int W  = 2,
  parameter int WN = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [WN-1:0] n,
  input  logic [WN-1:0] m,
  output logic [W-1:0]  cen,
  output logic [W-1:0]  cenb
);

  logic [WN:0]  acc;
  logic [WN:0]  next;
  logic [WN:0]  n_ext;
  logic [WN:0]  m_ext;
  logic         half;
  logic [W-1:0] edgecnt;
  logic [W-1:0] toggle;
  logic         over;
  logic         halfway;
  logic         recover;

  always_comb begin
    n_ext   = {1'b0, n};
    m_ext   = {1'b0, m};
    next    = acc + n_ext;
    over    = (next >= m_ext);
    halfway = (next >= {2'b00, m[WN-1:1]}) && !half;
    // Bits of edgecnt that rise on the next increment select which sub-rate outputs fire.
    toggle  = (edgecnt + W'(1)) & ~edgecnt;
    // m+n cannot overflow WN+1 bits, so this bound is exact.
    recover = (acc >= (m_ext + n_ext));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc     <= '0;
      half    <= 1'b0;
      edgecnt <= '0;
      cen     <= '0;
      cenb    <= '0;
    end else begin
      cen  <= '0;
      cenb <= '0;
      if (recover) begin
        acc <= '0;
      end else if (halfway) begin
        half    <= 1'b1;
        cenb[0] <= 1'b1;
      end
      // Wrap-around takes precedence over the recovery clear.
      if (over) begin
        acc     <= next - m_ext;
        half    <= 1'b0;
        edgecnt <= edgecnt + W'(1);
        cen     <= {toggle[W-2:0], 1'b1};
      end else if (!recover) begin
        acc <= next;
      end
    end
  end

endmodule

// File: tb/tb_frac_cen_gen.sv
// Self-checking bench for frac_cen_gen: directed scenarios plus randomized n/m
// segments, all compared against a behavioural model of the enable generator.
module tb_frac_cen_gen;

  localparam int W      = 3;
  localparam int WN     = 10;
  localparam int ACCMOD = 1 << (WN + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic [WN-1:0] n;
  logic [WN-1:0] m;
  logic [W-1:0]  cen;
  logic [W-1:0]  cenb;

  frac_cen_gen #(.W(W), .WN(WN)) dut (
    .clk (clk),
    .rst (rst),
    .n   (n),
    .m   (m),
    .cen (cen),
    .cenb(cenb)
  );

  always #5 clk = ~clk;

  int errCount   = 0;
  int checkCount = 0;

  // Reference model state: accumulator value, half-period flag and pulse number.
  int           mAcc;
  bit           mHalf;
  int           mPulses;
  logic [W-1:0] mCen;
  logic [W-1:0] mCenb;

  int cen0Cnt, cen1Cnt, cenb0Cnt, cenb1Cnt, bothCnt;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      errCount++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Advances the model by one clock edge using the inputs presented before that edge.
  task automatic modelStep();
    int  nv, mv, nx, newAcc;
    bit  ov, hw, rec, newHalf;
    if (rst) begin
      mAcc = 0; mHalf = 0; mPulses = 0; mCen = '0; mCenb = '0;
    end else begin
      nv      = int'(n);
      mv      = int'(m);
      nx      = (mAcc + nv) % ACCMOD;
      ov      = (nx >= mv);
      hw      = (nx >= mv / 2) && !mHalf;
      rec     = (mAcc >= mv + nv);
      newAcc  = mAcc;
      newHalf = mHalf;
      mCen    = '0;
      mCenb   = '0;
      if (rec) newAcc = 0;
      else if (hw) begin
        newHalf  = 1;
        mCenb[0] = 1'b1;
      end
      if (ov) begin
        newAcc  = nx - mv;
        newHalf = 0;
        mPulses++;
        mCen[0] = 1'b1;
        for (int k = 1; k < W; k++)
          if ((mPulses % (1 << k)) == (1 << (k - 1))) mCen[k] = 1'b1;
      end else if (!rec) begin
        newAcc = nx;
      end
      mAcc  = newAcc;
      mHalf = newHalf;
    end
  endtask

  task automatic clearCounts();
    cen0Cnt = 0; cen1Cnt = 0; cenb0Cnt = 0; cenb1Cnt = 0; bothCnt = 0;
  endtask

  // Presents one set of inputs for one clock cycle and checks the result after the edge.
  task automatic applyStimulus(input logic r, input int nv, input int mv);
    rst = r;
    n   = WN'(nv);
    m   = WN'(mv);
    modelStep();
    @(posedge clk);
    #1;
    checkOutput("cen", 32'(cen), 32'(mCen));
    checkOutput("cenb", 32'(cenb), 32'(mCenb));
    checkOutput("acc", 32'(dut.acc), 32'(mAcc));
    cen0Cnt  += int'(cen[0]);
    cen1Cnt  += int'(cen[1]);
    cenb0Cnt += int'(cenb[0]);
    cenb1Cnt += int'(cenb[1]);
    bothCnt  += int'(cen[0] & cenb[0]);
  endtask

  initial begin
    int mv, nv, cycles;
    rst = 1'b1;
    n   = '0;
    m   = '0;
    mAcc = 0; mHalf = 0; mPulses = 0; mCen = '0; mCenb = '0;

    $display("[TB] n=1 m=4 from reset");
    repeat (3) applyStimulus(1'b1, 1, 4);
    checkOutput("reset_cen", 32'(cen), 32'd0);
    applyStimulus(1'b0, 1, 4);
    checkOutput("first_cenb_early", 32'(cenb[0]), 32'd0);
    applyStimulus(1'b0, 1, 4);
    checkOutput("first_cenb", 32'(cenb[0]), 32'd1);
    applyStimulus(1'b0, 1, 4);
    checkOutput("first_cen_early", 32'(cen), 32'd0);
    applyStimulus(1'b0, 1, 4);
    checkOutput("pulse1", 32'(cen), 32'b011);
    repeat (4) applyStimulus(1'b0, 1, 4);
    checkOutput("pulse2", 32'(cen), 32'b101);
    repeat (4) applyStimulus(1'b0, 1, 4);
    checkOutput("pulse3", 32'(cen), 32'b011);

    $display("[TB] n=105 m=704 long run");
    repeat (2) applyStimulus(1'b1, 105, 704);
    clearCounts();
    repeat (704 * 100) applyStimulus(1'b0, 105, 704);
    checkOutput("ym_cen0_count", 32'(cen0Cnt), 32'd10500);
    checkOutput("ym_cen1_count", 32'(cen1Cnt), 32'd5250);
    checkOutput("ym_cenb0_count", 32'(cenb0Cnt), 32'd10500);
    checkOutput("ym_cenb1_count", 32'(cenb1Cnt), 32'd0);

    $display("[TB] n=m and n=0 boundaries");
    applyStimulus(1'b1, 8, 8);
    clearCounts();
    repeat (16) applyStimulus(1'b0, 8, 8);
    checkOutput("full_cen0", 32'(cen0Cnt), 32'd16);
    checkOutput("full_cen1", 32'(cen1Cnt), 32'd8);
    applyStimulus(1'b1, 0, 8);
    clearCounts();
    repeat (1000) applyStimulus(1'b0, 0, 8);
    checkOutput("zero_cen0", 32'(cen0Cnt), 32'd0);
    checkOutput("zero_cenb0", 32'(cenb0Cnt), 32'd0);
    applyStimulus(1'b1, 0, 0);
    clearCounts();
    repeat (10) applyStimulus(1'b0, 0, 0);
    checkOutput("m0_cen0", 32'(cen0Cnt), 32'd10);

    $display("[TB] n=1 m=2");
    applyStimulus(1'b1, 1, 2);
    clearCounts();
    repeat (20) applyStimulus(1'b0, 1, 2);
    checkOutput("half_cen0", 32'(cen0Cnt), 32'd10);
    checkOutput("half_cenb0", 32'(cenb0Cnt), 32'd10);
    checkOutput("half_overlap", 32'(bothCnt), 32'd0);

    $display("[TB] reset mid-period n=3 m=10");
    applyStimulus(1'b1, 3, 10);
    repeat (17) applyStimulus(1'b0, 3, 10);
    applyStimulus(1'b1, 3, 10);
    checkOutput("midrst_cen", 32'(cen), 32'd0);
    checkOutput("midrst_acc", 32'(dut.acc), 32'd0);
    repeat (30) applyStimulus(1'b0, 3, 10);

    $display("[TB] n switch 9 -> 1 at m=10");
    applyStimulus(1'b1, 9, 10);
    cycles = 0;
    do begin
      applyStimulus(1'b0, 9, 10);
      cycles++;
    end while (mAcc < 8 && cycles < 40);
    checkOutput("switch_reached", 32'(mAcc >= 8), 32'd1);
    repeat (20) applyStimulus(1'b0, 1, 10);
    for (int w = 0; w < 3; w++) begin
      clearCounts();
      repeat (10) applyStimulus(1'b0, 1, 10);
      checkOutput("switch_window", 32'(cen0Cnt), 32'd1);
    end

    $display("[TB] randomized segments");
    for (int s = 0; s < 12; s++) begin
      mv = int'($urandom_range(1, 1023));
      nv = int'($urandom_range(0, mv));
      applyStimulus(1'b1, nv, mv);
      repeat (200) applyStimulus(1'b0, nv, mv);
      if (s % 3 == 1) mv = int'($urandom_range(1, 1023));
      nv = int'($urandom_range(0, mv));
      repeat (200) applyStimulus(1'b0, nv, mv);
    end

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
